// File: rtl/dtcm_resp.sv
// -----------------------------------------------------------------------------
// dtcm_resp
//   Zero-latency data tightly-coupled memory for a simple core. A word-access
//   RAM occupies the low half of the address space. A small MMIO block in the
//   upper half holds a free-running 64-bit timer with compare interrupt and a
//   TOHOST mailbox that test programs use to signal completion.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   dtcm_mem_write : store request, sampled each cycle
//   dtcm_mem_read  : load request, data returned in the same cycle
//   dtcm_addr      : byte address, bits [1:0] ignored
//   dtcm_dataout   : store data from the core
//   dtcm_datain    : load data to the core (0 when not reading or on a fault)
//   timer_irq      : registered (mtime >= mtimecmp)
//   access_err     : one-cycle pulse in the cycle after a faulting access
//   tohost_done    : sticky, set by the first nonzero TOHOST write
//   tohost_code    : last nonzero value written to TOHOST
// -----------------------------------------------------------------------------
module dtcm_resp #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dtcm_mem_write,
  input  logic        dtcm_mem_read,
  input  logic [31:0] dtcm_addr,
  input  logic [31:0] dtcm_dataout,
  output logic [31:0] dtcm_datain,
  output logic        timer_irq,
  output logic        access_err,
  output logic        tohost_done,
  output logic [31:0] tohost_code
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    MMIO_MTIME_LO    = 3'd0,
    MMIO_MTIME_HI    = 3'd1,
    MMIO_MTIMECMP_LO = 3'd2,
    MMIO_MTIMECMP_HI = 3'd3,
    MMIO_TOHOST      = 3'd4,
    MMIO_RSVD5       = 3'd5,
    MMIO_RSVD6       = 3'd6,
    MMIO_RSVD7       = 3'd7
  } mmio_sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_hi_snap;
  logic        r_timer_irq;
  logic        r_access_err;
  logic        r_tohost_done;
  logic [31:0] r_tohost_code;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          w_is_mmio;
  logic [AW-1:0] w_ram_idx;
  mmio_sel_e     w_mmio_sel;
  logic          w_fault;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic          w_mtime_lo_rd;
  logic          w_unused_addr;
  logic [31:0]   w_rdata;

  assign w_is_mmio  = dtcm_addr[31];
  assign w_ram_idx  = dtcm_addr[AW+1:2];
  assign w_mmio_sel = mmio_sel_e'(dtcm_addr[4:2]);

  // Any set bit between the decoded field and bit 31 is outside the region.
  assign w_fault = w_is_mmio ? (|dtcm_addr[30:5]) : (|dtcm_addr[30:AW+2]);

  // Word access only: the byte offset carries no information.
  assign w_unused_addr = ^dtcm_addr[1:0];

  // rst_n gates the RAM strobe so a store in flight when reset asserts is
  // dropped, while the RAM itself stays a plain clocked array.
  assign w_ram_we      = rst_n & dtcm_mem_write & ~w_is_mmio & ~w_fault;
  assign w_mmio_we     = dtcm_mem_write & w_is_mmio & ~w_fault;
  assign w_mtime_lo_rd = dtcm_mem_read & w_is_mmio & ~w_fault &
                         (w_mmio_sel == MMIO_MTIME_LO);

  // ---------------------------------------------------------------------------
  // Combinational read path (same-cycle data). A simultaneous write only
  // lands at the closing edge, so this naturally returns the old value.
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb is given a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    if (dtcm_mem_read && !w_fault) begin
      if (w_is_mmio) begin
        case (w_mmio_sel)
          MMIO_MTIME_LO:    w_rdata = r_mtime[31:0];
          MMIO_MTIME_HI:    w_rdata = r_hi_snap;
          MMIO_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
          MMIO_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
          MMIO_TOHOST:      w_rdata = r_tohost_code;
          default:          w_rdata = '0;
        endcase
      end else begin
        w_rdata = r_mem[w_ram_idx];
      end
    end
  end

  assign dtcm_datain = w_rdata;

  // ---------------------------------------------------------------------------
  // RAM array
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset branch on purpose; clearing an array forces it
  // into flops and its contents are defined by software, not by reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= dtcm_dataout;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer, mailbox and error registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; r_timer_irq therefore compares the mtime and
  // mtimecmp of the cycle just ending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime       <= '0;
      r_mtimecmp    <= '1;
      r_hi_snap     <= '0;
      r_timer_irq   <= 1'b0;
      r_access_err  <= 1'b0;
      r_tohost_done <= 1'b0;
      r_tohost_code <= '0;
    end else begin
      r_mtime      <= r_mtime + 64'd1;
      r_timer_irq  <= (r_mtime >= r_mtimecmp);
      r_access_err <= (dtcm_mem_read | dtcm_mem_write) & w_fault;

      // Reading the low half freezes the high half so a LO/HI pair is coherent.
      if (w_mtime_lo_rd) begin
        r_hi_snap <= r_mtime[63:32];
      end

      if (w_mmio_we) begin
        case (w_mmio_sel)
          MMIO_MTIMECMP_LO: r_mtimecmp[31:0]  <= dtcm_dataout;
          MMIO_MTIMECMP_HI: r_mtimecmp[63:32] <= dtcm_dataout;
          MMIO_TOHOST: begin
            if (dtcm_dataout != 32'd0) begin
              r_tohost_done <= 1'b1;
              r_tohost_code <= dtcm_dataout;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign timer_irq   = r_timer_irq;
  assign access_err  = r_access_err;
  assign tohost_done = r_tohost_done;
  assign tohost_code = r_tohost_code;

endmodule
